decode_rf_scoreboard: RTL and testbench
=======================================

// Module: decode_rf_scoreboard
// PURPOSE
// Parametrised decode-stage register read with scoreboard interlock. Reads two source
// operands from an internal register file (write-before-read bypass from writeback),
// tracks in-flight writes per register, stalls issue on RAW hazards, and registers
// operands into a valid/ready output stage feeding ID/EX. Sequences HALT into drain/dump.
// PARAMETERS
// DATA_W      16  operand/register width
// NUM_REGS    8   architectural registers (power of 2, >=2)
// ADDR_W      $clog2(NUM_REGS)  register select width (derived, not overridden)
// MAX_INFL    3   max in-flight writes per register; counter width CNT_W=$clog2(MAX_INFL+1)
// PORTS
// clk         in   1       clock, rising edge
// rst         in   1       reset, asynchronous, active-high
// in_valid    in   1       decoded instruction present
// in_ready    out  1       instruction accepted this cycle when in_valid&in_ready
// in_rs/in_rt in   ADDR_W  source selects; in_rs_used/in_rt_used (1b each) qualify them
// in_rd       in   ADDR_W  destination; in_rd_wr (1b) = instruction will write in_rd
// in_halt     in   1       HALT opcode
// wb_en       in   1       writeback strobe; wb_sel ADDR_W, wb_data DATA_W
// out_valid   out  1       ID/EX payload valid
// out_ready   in   1       downstream accepts payload
// out_a/out_b out  DATA_W  operands; out_rd ADDR_W, out_rd_wr 1b passed through
// dump        out  1       level: halted, scoreboard empty
// err         out  1       sticky protocol error
// BEHAVIOUR
// Reset (async): all registers 0, all counters 0, state RUN, out_valid 0, out_a/out_b/
//   out_rd/out_rd_wr 0, dump 0, err 0. Reset mid-drain returns to RUN.
// Register file: write on clk when wb_en. Read is combinational with bypass: if wb_en and
//   wb_sel==sel, read value = wb_data.
// Scoreboard cnt[r]: +1 when accept & in_rd_wr & in_rd==r; -1 when wb_en & wb_sel==r;
//   both same cycle same r -> unchanged. wb_en to r with cnt[r]==0 -> err=1, cnt stays 0.
// Hazard (per used source s): cnt[s]>1, or cnt[s]==1 and not (wb_en & wb_sel==s).
//   cnt[s]==1 with matching writeback this cycle -> no stall, bypassed value issued.
// Structural stall: in_rd_wr & cnt[in_rd]==MAX_INFL.
// in_ready = state==RUN & (!out_valid | out_ready) & !hazard & !structural stall.
//   in_ready does not depend on in_valid.
// Accept: output stage loads operands/rd fields next edge; out_valid=1. Latency 1 cycle.
// Output stage: holds stable while out_valid & !out_ready. Clears out_valid on
//   out_ready & no new accept.
// FSM: RUN -> DRAIN on accepted in_halt. HALT itself is issued (out_valid) with no rd write.
//   DRAIN -> HALTED when all cnt==0 and !out_valid.
//   HALTED is terminal until reset; dump=1 in HALTED only.
//   in_ready=0 in DRAIN/HALTED; wb still processed.
// Width rules: counters saturate as specified, never wrap. ADDR_W compare is full width.
// STRUCTURE
// Shared package decode_pkg: state enum {RUN,DRAIN,HALTED}, localparam widths, and an
//   id_ex_t struct for the output payload.
// Sub-module rf_array (NUM_REGS x DATA_W, 2 read, 1 write, bypass) holds storage.
//   Scoreboard, FSM and output stage sit in this module.
// TESTING
// Write R3=0x1234 via wb; issue rs=3 -> out_a=0x1234 one cycle after accept.
// Issue rd=2 wr; next insn rs=2 -> in_ready=0 until wb_sel=2 wb_data=0xBEEF,
//   accepted that cycle, out_a=0xBEEF.
// Issue 3 writes to R5 -> 4th writer to R5 stalls. One wb to R5 -> 4th accepted;
//   cnt[5] stays 3.
// out_ready=0 for 4 cycles with out_valid=1 -> payload stable; in_ready=0.
// HALT with one write pending -> DRAIN; dump=0 until wb clears cnt and out drained,
//   then dump=1 and in_ready stays 0.
// wb to register with cnt 0 -> err=1 and stays 1. Assert rst mid-DRAIN -> all outputs 0,
//   state RUN next cycle.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: shared decode-stage types and default sizing
package decode_pkg;
   localparam int PKG_DATA_W   = 16;
   localparam int PKG_NUM_REGS = 8;
   localparam int PKG_ADDR_W   = $clog2(PKG_NUM_REGS);
   localparam int PKG_MAX_INFL = 3;
   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
   typedef struct packed {
      logic [PKG_DATA_W-1:0] a;
      logic [PKG_DATA_W-1:0] b;
      logic [PKG_ADDR_W-1:0] rd;
      logic                  rd_wr;
   } id_ex_t;
endpackage

// File: rtl/rf_array.sv
// rf_array: NUM_REGS x DATA_W register file, two combinational reads, one write
//   clk, rst           clock, async active-high reset (clears all registers)
//   we, wsel, wdata    write port, written on the rising edge
//   sel_a/sel_b        read selects; rdata_a/rdata_b see a same-cycle write (bypass)
module rf_array
   import decode_pkg::*;
#(
   parameter int DATA_W   = PKG_DATA_W,
   parameter int NUM_REGS = PKG_NUM_REGS
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         we,
   input  logic [$clog2(NUM_REGS)-1:0]  wsel,
   input  logic [DATA_W-1:0]            wdata,
   input  logic [$clog2(NUM_REGS)-1:0]  sel_a,
   input  logic [$clog2(NUM_REGS)-1:0]  sel_b,
   output logic [DATA_W-1:0]            rdata_a,
   output logic [DATA_W-1:0]            rdata_b
);
   logic [DATA_W-1:0] mem [NUM_REGS];
   always_ff @(posedge clk or posedge rst)
      if (rst) for (int r = 0; r < NUM_REGS; r++) mem[r] <= '0;
      else if (we) mem[wsel] <= wdata;
   assign rdata_a = (we && wsel == sel_a) ? wdata : mem[sel_a];
   assign rdata_b = (we && wsel == sel_b) ? wdata : mem[sel_b];
endmodule

// File: rtl/decode_rf_scoreboard.sv
// decode_rf_scoreboard: register read with scoreboard interlock and ID/EX output stage
//   clk, rst                      clock, async active-high reset
//   in_valid/in_ready             decoded instruction handshake
//   in_rs/in_rt (+_used)          source selects and their qualifiers
//   in_rd, in_rd_wr, in_halt      destination, write flag, HALT opcode
//   wb_en, wb_sel, wb_data        writeback into the register file
//   out_valid/out_ready           ID/EX payload handshake
//   out_a, out_b, out_rd, out_rd_wr  payload
//   dump                          halted with empty scoreboard
//   err                           sticky: writeback to a register with no write in flight
module decode_rf_scoreboard
   import decode_pkg::*;
#(
   parameter int DATA_W   = PKG_DATA_W,
   parameter int NUM_REGS = PKG_NUM_REGS,
   parameter int MAX_INFL = PKG_MAX_INFL
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [$clog2(NUM_REGS)-1:0]  in_rs,
   input  logic                         in_rs_used,
   input  logic [$clog2(NUM_REGS)-1:0]  in_rt,
   input  logic                         in_rt_used,
   input  logic [$clog2(NUM_REGS)-1:0]  in_rd,
   input  logic                         in_rd_wr,
   input  logic                         in_halt,
   input  logic                         wb_en,
   input  logic [$clog2(NUM_REGS)-1:0]  wb_sel,
   input  logic [DATA_W-1:0]            wb_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_W-1:0]            out_a,
   output logic [DATA_W-1:0]            out_b,
   output logic [$clog2(NUM_REGS)-1:0]  out_rd,
   output logic                         out_rd_wr,
   output logic                         dump,
   output logic                         err
);
   localparam int ADDR_W = $clog2(NUM_REGS);
   localparam int CNT_W  = $clog2(MAX_INFL + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFL);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   state_t state, state_nx;
   id_ex_t q;
   logic [CNT_W-1:0] cnt    [NUM_REGS];
   logic [CNT_W-1:0] cnt_nx [NUM_REGS];
   logic [NUM_REGS-1:0] inc, dec;
   logic [DATA_W-1:0] rd_a, rd_b;
   logic wr_eff, haz_rs, haz_rt, full, accept, sb_empty;
   rf_array #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_rf (
      .clk(clk), .rst(rst), .we(wb_en), .wsel(wb_sel), .wdata(wb_data),
      .sel_a(in_rs), .sel_b(in_rt), .rdata_a(rd_a), .rdata_b(rd_b)
   );
   // HALT never claims its rd, even if the decoder left in_rd_wr set
   assign wr_eff = in_rd_wr & ~in_halt;
   // A single pending write resolving this cycle is covered by the rf bypass
   assign haz_rs = in_rs_used & ((cnt[in_rs] > CNT_ONE) | (cnt[in_rs] == CNT_ONE & ~(wb_en & wb_sel == in_rs)));
   assign haz_rt = in_rt_used & ((cnt[in_rt] > CNT_ONE) | (cnt[in_rt] == CNT_ONE & ~(wb_en & wb_sel == in_rt)));
   assign full = wr_eff & (cnt[in_rd] == CNT_MAX);
   assign in_ready = (state == RUN) & (~out_valid | out_ready) & ~haz_rs & ~haz_rt & ~full;
   assign accept = in_valid & in_ready;
   always_comb begin
      inc = '0;
      dec = '0;
      sb_empty = 1'b1;
      for (int r = 0; r < NUM_REGS; r++) begin
         inc[r] = accept & wr_eff & (in_rd == ADDR_W'(r));
         dec[r] = wb_en & (wb_sel == ADDR_W'(r));
         cnt_nx[r] = (inc[r] & ~dec[r] & cnt[r] != CNT_MAX) ? cnt[r] + 1'b1 :
                     (dec[r] & ~inc[r] & cnt[r] != '0) ? cnt[r] - 1'b1 : cnt[r];
         if (cnt[r] != '0) sb_empty = 1'b0;
      end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      else for (int r = 0; r < NUM_REGS; r++) cnt[r] <= cnt_nx[r];
   always_ff @(posedge clk or posedge rst)
      if (rst) err <= 1'b0;
      else if (wb_en && cnt[wb_sel] == '0) err <= 1'b1;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         out_valid <= 1'b0;
         q <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         q <= '{a: rd_a, b: rd_b, rd: in_rd, rd_wr: wr_eff};
      end else if (out_ready) out_valid <= 1'b0;
   assign out_a     = q.a;
   assign out_b     = q.b;
   assign out_rd    = q.rd;
   assign out_rd_wr = q.rd_wr;
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= RUN;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      if (state == RUN && accept && in_halt) state_nx = DRAIN;
      else if (state == DRAIN && sb_empty && !out_valid) state_nx = HALTED;
   end
   assign dump = (state == HALTED);
endmodule

// File: tb/tb_decode_rf_scoreboard.sv
// tb_decode_rf_scoreboard: random and directed checks against a behavioural model
module tb_decode_rf_scoreboard;
   localparam int MI = 3;
   logic clk = 0, rst = 0;
   logic in_valid = 0, in_ready, in_rs_used = 0, in_rt_used = 0, in_rd_wr = 0, in_halt = 0;
   logic [2:0] in_rs = 0, in_rt = 0, in_rd = 0, wb_sel = 0, out_rd;
   logic wb_en = 0, out_valid, out_ready = 0, out_rd_wr, dump, err;
   logic [15:0] wb_data = 0, out_a, out_b;
   decode_rf_scoreboard dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_rs(in_rs), .in_rs_used(in_rs_used), .in_rt(in_rt), .in_rt_used(in_rt_used),
      .in_rd(in_rd), .in_rd_wr(in_rd_wr), .in_halt(in_halt),
      .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
      .out_rd(out_rd), .out_rd_wr(out_rd_wr), .dump(dump), .err(err)
   );
   always #5 clk = ~clk;
   int vectors = 0, miscompares = 0;
   logic last_ready;
   logic [15:0] mrf [8];
   int mc [8];
   int mst;
   bit mov, merr, mowr;
   logic [15:0] moa, mob;
   logic [2:0] mord;
   int cands[$];
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [15:0] m_read(input logic [2:0] s);
      return (wb_en && wb_sel == s) ? wb_data : mrf[s];
   endfunction
   function automatic bit m_haz(input bit used, input logic [2:0] s);
      return used && (mc[s] > 1 || (mc[s] == 1 && !(wb_en && wb_sel == s)));
   endfunction
   function automatic bit m_ready();
      return mst == 0 && (!mov || out_ready) && !m_haz(in_rs_used, in_rs) && !m_haz(in_rt_used, in_rt)
             && !(in_rd_wr && !in_halt && mc[in_rd] == MI);
   endfunction
   task automatic model_reset();
      for (int r = 0; r < 8; r++) begin
         mrf[r] = 0;
         mc[r] = 0;
      end
      mst = 0; mov = 0; merr = 0; mowr = 0; moa = 0; mob = 0; mord = 0;
   endtask
   task automatic step(input bit v, input logic [2:0] rs, input bit rsu, input logic [2:0] rt, input bit rtu,
                       input logic [2:0] rd, input bit wr, input bit halt, input bit ordy,
                       input bit we, input logic [2:0] ws, input logic [15:0] wd);
      bit rdy, acc, empty;
      int nst, n;
      @(negedge clk);
      in_valid = v; in_rs = rs; in_rs_used = rsu; in_rt = rt; in_rt_used = rtu;
      in_rd = rd; in_rd_wr = wr; in_halt = halt; out_ready = ordy;
      wb_en = we; wb_sel = ws; wb_data = wd;
      #1;
      rdy = m_ready();
      chk("in_ready", 32'(in_ready), 32'(rdy));
      last_ready = in_ready;
      acc = v && rdy;
      empty = 1;
      for (int r = 0; r < 8; r++) if (mc[r] != 0) empty = 0;
      nst = (mst == 0 && acc && halt) ? 1 : (mst == 1 && empty && !mov) ? 2 : mst;
      if (acc) begin
         moa = m_read(rs); mob = m_read(rt); mord = rd; mowr = wr && !halt; mov = 1;
      end else if (ordy) mov = 0;
      if (we && mc[ws] == 0) merr = 1;
      for (int r = 0; r < 8; r++) begin
         n = mc[r] + int'(acc && wr && !halt && rd == r) - int'(we && ws == r);
         mc[r] = n < 0 ? 0 : n;
      end
      if (we) mrf[ws] = wd;
      mst = nst;
      @(posedge clk);
      #1;
      chk("out_valid", 32'(out_valid), 32'(mov));
      chk("out_a", 32'(out_a), 32'(moa));
      chk("out_b", 32'(out_b), 32'(mob));
      chk("out_rd", 32'(out_rd), 32'(mord));
      chk("out_rd_wr", 32'(out_rd_wr), 32'(mowr));
      chk("err", 32'(err), 32'(merr));
      chk("dump", 32'(dump), 32'(mst == 2));
   endtask
   task automatic idle(input bit ordy);
      step(0, 0, 0, 0, 0, 0, 0, 0, ordy, 0, 0, 0);
   endtask
   task automatic do_reset();
      @(negedge clk);
      #2;
      rst = 1;
      in_valid = 0; in_rs_used = 0; in_rt_used = 0; in_rd_wr = 0; in_halt = 0; wb_en = 0; out_ready = 0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_a", 32'(out_a), 0);
      chk("rst_out_b", 32'(out_b), 0);
      chk("rst_out_rd", 32'(out_rd), 0);
      chk("rst_out_rd_wr", 32'(out_rd_wr), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_dump", 32'(dump), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      model_reset();
      @(negedge clk);
      rst = 0;
   endtask
   initial begin
      bit we;
      logic [2:0] ws;
      do_reset();
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 16'h1234);
      step(1, 3, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      chk("t1_out_a", 32'(out_a), 32'h1234);
      chk("t1_err", 32'(err), 1);
      idle(1);
      chk("t1_err_sticky", 32'(err), 1);
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         cands.delete();
         for (int r = 0; r < 8; r++) if (mc[r] > 0) cands.push_back(r);
         we = cands.size() > 0 && $urandom_range(1, 0) == 1;
         ws = we ? 3'(cands[$urandom_range(cands.size() - 1, 0)]) : 3'($urandom);
         step($urandom_range(3, 0) != 0, 3'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
              3'($urandom), 1'($urandom), 0, $urandom_range(3, 0) != 0, we, ws, 16'($urandom));
      end
      do_reset();
      step(1, 0, 0, 0, 0, 2, 1, 0, 1, 0, 0, 0);
      step(1, 2, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      chk("t2_stall", 32'(last_ready), 0);
      step(1, 2, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      chk("t2_stall2", 32'(last_ready), 0);
      step(1, 2, 1, 0, 0, 0, 0, 0, 1, 1, 2, 16'hBEEF);
      chk("t2_accept", 32'(last_ready), 1);
      chk("t2_out_a", 32'(out_a), 32'hBEEF);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 5, 1, 0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 5, 1, 0, 1, 0, 0, 0);
      chk("t3_full", 32'(last_ready), 0);
      step(1, 0, 0, 0, 0, 5, 1, 0, 1, 1, 5, 16'h0055);
      step(1, 0, 0, 0, 0, 5, 1, 0, 1, 0, 0, 0);
      chk("t3_fourth", 32'(last_ready), 1);
      step(1, 0, 0, 0, 0, 5, 1, 0, 1, 0, 0, 0);
      chk("t3_resat", 32'(last_ready), 0);
      do_reset();
      step(1, 0, 0, 0, 0, 6, 1, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6, 16'hA5A5);
      step(1, 6, 1, 6, 1, 3, 1, 0, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         chk("t4_blocked", 32'(last_ready), 0);
         chk("t4_hold_a", 32'(out_a), 32'hA5A5);
         chk("t4_hold_rd", 32'(out_rd), 3);
      end
      idle(1);
      do_reset();
      step(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      chk("t5_halt_acc", 32'(last_ready), 1);
      chk("t5_halt_rdwr", 32'(out_rd_wr), 0);
      idle(1);
      idle(1);
      chk("t5_drain_ready", 32'(last_ready), 0);
      chk("t5_drain_dump", 32'(dump), 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 16'h0101);
      chk("t5_wb_dump", 32'(dump), 0);
      idle(1);
      chk("t5_dump", 32'(dump), 1);
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      chk("t5_halted_ready", 32'(last_ready), 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4, 16'h0004);
      chk("t6_err", 32'(err), 1);
      idle(1);
      chk("t6_err_sticky", 32'(err), 1);
      do_reset();
      step(1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      idle(1);
      chk("t7_in_drain", 32'(last_ready), 0);
      do_reset();
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      chk("t7_run", 32'(last_ready), 1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
